// File: rtl/avalon_pio_gpio.sv
// Avalon-MM GPIO slave: per-bit direction, set/clear, synchronised inputs,
// edge capture with write-1-to-clear and a maskable, registered interrupt.
`timescale 1ns/1ps
module avalon_pio_gpio #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0,
  parameter int unsigned      EDGE_TYPE   = 0,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_en,
  output logic             irq
);

  localparam logic [2:0] WARM = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [2:0]       warm_q, warm_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] rise, fall, any_e;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] rval;
  logic             wr;
  logic             unused_wd;

  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign wr        = chipselect & ~write_n;
  assign in_sync   = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < int'(SYNC_STAGES); i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  always_comb begin
    rise  = in_sync & ~prev_q;
    fall  = ~in_sync & prev_q;
    any_e = in_sync ^ prev_q;
    det   = '0;
    // Suppress detection until the sync chain holds real pin samples
    if (warm_q == 3'd0) begin
      if (EDGE_TYPE == 0)      det = rise;
      else if (EDGE_TYPE == 1) det = fall;
      else                     det = any_e;
    end
  end

  always_comb begin
    data_d = data_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    clr    = '0;
    if (wr) begin
      unique case (address)
        3'd0:    data_d = wd;
        3'd1:    dir_d  = wd;
        3'd2:    mask_d = wd;
        3'd3:    clr    = wd;
        3'd4:    data_d = data_q | wd;
        3'd5:    data_d = data_q & ~wd;
        default: ;
      endcase
    end
    cap_d  = (cap_q & ~clr) | det;
    irq_d  = |(cap_q & mask_q);
    warm_d = (warm_q != 3'd0) ? warm_q - 3'd1 : warm_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      dir_q  <= RESET_DIR;
      mask_q <= '0;
      cap_q  <= '0;
      prev_q <= '0;
      warm_q <= WARM;
      irq_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      dir_q  <= dir_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
      prev_q <= in_sync;
      warm_q <= warm_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    rval     = '0;
    readdata = '0;
    if (chipselect) begin
      unique case (address)
        3'd0:    rval = (data_q & dir_q) | (in_sync & ~dir_q);
        3'd1:    rval = dir_q;
        3'd2:    rval = mask_q;
        3'd3:    rval = cap_q;
        default: rval = '0;
      endcase
    end
    readdata[WIDTH-1:0] = rval;
  end

  assign out_port = data_q;
  assign out_en   = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_avalon_pio_gpio.sv
// Directed bench for avalon_pio_gpio: vector table for register access,
// hand sequences for edge timing, set-wins race and warm-up.
`timescale 1ns/1ps
module tb_avalon_pio_gpio;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  in_port = '0;
  logic [7:0]  out_port;
  logic [7:0]  out_en;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic        cs;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [7:0]  inp;
    logic [7:0]  exp_out;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  avalon_pio_gpio #(
    .WIDTH(8),
    .RESET_VALUE(8'hA5),
    .RESET_DIR(8'hFF),
    .EDGE_TYPE(0),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .in_port(in_port),
    .out_port(out_port),
    .out_en(out_en),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  function automatic vec_t mk(input logic w, input logic c,
                              input logic [2:0] a, input logic [31:0] d,
                              input logic [7:0] i, input logic [7:0] eo,
                              input logic [31:0] er);
    vec_t v;
    v.wr = w; v.cs = c; v.addr = a; v.wd = d;
    v.inp = i; v.exp_out = eo; v.exp_rd = er;
    return v;
  endfunction

  initial begin
    logic [31:0] d;

    vecs.push_back(mk(1, 1, 3'd0, 32'h1234_560F, 8'h00, 8'h0F, 0));
    vecs.push_back(mk(1, 1, 3'd4, 32'h0000_0030, 8'h00, 8'h3F, 0));
    vecs.push_back(mk(1, 1, 3'd5, 32'h0000_0003, 8'h00, 8'h3C, 0));
    vecs.push_back(mk(0, 1, 3'd0, 0, 8'h00, 8'h3C, 32'h3C));
    vecs.push_back(mk(1, 1, 3'd1, 32'h0000_00F0, 8'h05, 8'h3C, 0));
    vecs.push_back(mk(1, 1, 3'd0, 32'h0000_00A0, 8'h05, 8'hA0, 0));
    vecs.push_back(mk(0, 1, 3'd1, 0, 8'h05, 8'hA0, 32'hF0));
    vecs.push_back(mk(0, 1, 3'd0, 0, 8'h05, 8'hA0, 32'hA5));
    vecs.push_back(mk(0, 1, 3'd3, 0, 8'h05, 8'hA0, 32'h05));
    vecs.push_back(mk(0, 1, 3'd2, 0, 8'h05, 8'hA0, 32'h00));
    vecs.push_back(mk(0, 1, 3'd4, 0, 8'h05, 8'hA0, 32'h00));
    vecs.push_back(mk(0, 1, 3'd5, 0, 8'h05, 8'hA0, 32'h00));
    vecs.push_back(mk(0, 1, 3'd6, 0, 8'h05, 8'hA0, 32'h00));
    vecs.push_back(mk(0, 1, 3'd7, 0, 8'h05, 8'hA0, 32'h00));
    vecs.push_back(mk(1, 1, 3'd6, 32'hFFFF_FFFF, 8'h05, 8'hA0, 0));
    vecs.push_back(mk(1, 1, 3'd7, 32'hFFFF_FFFF, 8'h05, 8'hA0, 0));
    vecs.push_back(mk(0, 1, 3'd1, 0, 8'h05, 8'hA0, 32'hF0));
    vecs.push_back(mk(0, 1, 3'd2, 0, 8'h05, 8'hA0, 32'h00));
    vecs.push_back(mk(1, 1, 3'd3, 32'h0000_00FF, 8'h05, 8'hA0, 0));
    vecs.push_back(mk(0, 1, 3'd3, 0, 8'h05, 8'hA0, 32'h00));
    vecs.push_back(mk(0, 0, 3'd1, 0, 8'h05, 8'hA0, 32'h00));

    // reset values
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_out_port", 32'(out_port), 32'hA5);
    check("rst_out_en", 32'(out_en), 32'hFF);
    check("rst_irq", 32'(irq), 0);
    rd(3'd0, d);
    check("rst_rd_data", d, 32'h0000_00A5);
    rd(3'd3, d);
    check("rst_rd_edgecap", d, 0);

    // register vectors
    foreach (vecs[i]) begin
      @(negedge clk);
      in_port = vecs[i].inp;
      if (vecs[i].wr) begin
        address    = vecs[i].addr;
        writedata  = vecs[i].wd;
        chipselect = vecs[i].cs;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        check($sformatf("vec%0d_out", i), 32'(out_port),
              32'(vecs[i].exp_out));
      end else begin
        address    = vecs[i].addr;
        chipselect = vecs[i].cs;
        write_n    = 1'b1;
        #1;
        check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
        chipselect = 1'b0;
      end
    end
    check("out_en_dir", 32'(out_en), 32'hF0);

    // edge capture and irq latency
    @(negedge clk);
    in_port = 8'h00;
    repeat (4) @(negedge clk);
    wr(3'd3, 32'hFF);
    wr(3'd2, 32'h01);
    @(negedge clk);
    check("irq_idle", 32'(irq), 0);
    in_port = 8'h01;
    @(negedge clk);
    rd(3'd3, d);
    check("cap_c1", d, 0);
    @(negedge clk);
    rd(3'd3, d);
    check("cap_c2", d, 0);
    @(negedge clk);
    rd(3'd3, d);
    check("cap_c3", d, 32'h01);
    check("irq_c3", 32'(irq), 0);
    @(negedge clk);
    check("irq_c4", 32'(irq), 1);
    wr(3'd3, 32'h01);
    rd(3'd3, d);
    check("cap_w1c", d, 0);
    check("irq_w1c_same", 32'(irq), 1);
    @(posedge clk);
    #1;
    check("irq_w1c_next", 32'(irq), 0);

    // clear and rising edge on bit 2 in the same cycle
    @(negedge clk);
    in_port = 8'h05;
    @(negedge clk);
    @(negedge clk);
    address    = 3'd3;
    writedata  = 32'h04;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    rd(3'd3, d);
    check("race_set_wins", d, 32'h04);
    check("race_irq_masked", 32'(irq), 0);
    wr(3'd3, 32'h04);
    rd(3'd3, d);
    check("race_clear_after", d, 0);

    // pins high through reset never capture
    @(negedge clk);
    in_port = 8'hFF;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wr(3'd2, 32'hFF);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rd(3'd3, d);
      check($sformatf("warm_cap%0d", i), d, 0);
      check($sformatf("warm_irq%0d", i), 32'(irq), 0);
    end

    // reset in the middle of a capture
    @(negedge clk);
    in_port = 8'h00;
    repeat (4) @(negedge clk);
    in_port = 8'hFF;
    repeat (4) @(negedge clk);
    rd(3'd3, d);
    check("mid_cap_set", d, 32'hFF);
    check("mid_irq_set", 32'(irq), 1);
    #2;
    reset_n = 1'b0;
    #1;
    rd(3'd3, d);
    check("mid_rst_cap", d, 0);
    check("mid_rst_irq", 32'(irq), 0);
    check("mid_rst_out", 32'(out_port), 32'hA5);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
